divider_iterative_32b: RTL and testbench

Multi-cycle unsigned integer divider. It produces quotient and remainder by one restoring-subtract step per cycle, which is the inverse of the carry-chain adder datapath. It sits beside the ALU in the TinyRV1 datapath and is reached through a val/rdy request stream and a val/rdy response stream. Only one operation is in flight at a time.

---
 rtl/divider_iterative_32b.sv | 132 +++++++++++++
 tb/tb_divider_iterative_32b.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_iterative_32b.sv
// Multi-cycle restoring divider: one quotient bit per cycle behind val/rdy request/response streams.
// Optional DIVIDER_SIGNED_EN adds istream_signed for two's-complement operands (truncating division).
module divider_iterative_32b #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [WIDTH-1:0] istream_msg_a,
    input  logic [WIDTH-1:0] istream_msg_b,
`ifdef DIVIDER_SIGNED_EN
    input  logic             istream_signed,
`endif
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [WIDTH-1:0] ostream_msg_quot,
    output logic [WIDTH-1:0] ostream_msg_rem
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] div_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quot;
    logic [WIDTH-1:0] fin_rem;
    logic [WIDTH-1:0] fin_quot;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    // The working remainder is WIDTH+1 bits so the borrow shows up as trial's MSB;
    // the restored value is always < divisor, so only WIDTH bits need storing.
    always_comb begin
        shifted   = {rem_r, quot_r[WIDTH-1]};
        trial     = shifted - {1'b0, div_r};
        step_quot = {quot_r[WIDTH-2:0], ~trial[WIDTH]};
        step_rem  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

`ifdef DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic in_neg_q;
    logic in_neg_r;

    always_comb begin
        in_neg_r = istream_signed & istream_msg_a[WIDTH-1];
        in_neg_q = istream_signed & (istream_msg_a[WIDTH-1] ^ istream_msg_b[WIDTH-1]);
        in_a     = in_neg_r ? -istream_msg_a : istream_msg_a;
        in_b     = (istream_signed & istream_msg_b[WIDTH-1]) ? -istream_msg_b : istream_msg_b;
        fin_quot = neg_q ? -step_quot : step_quot;
        fin_rem  = neg_r ? -step_rem : step_rem;
    end
`else
    always_comb begin
        in_a     = istream_msg_a;
        in_b     = istream_msg_b;
        fin_quot = step_quot;
        fin_rem  = step_rem;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rem_r  <= '0;
            quot_r <= '0;
            div_r  <= '0;
`ifdef DIVIDER_SIGNED_EN
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (istream_val) begin
                        if (istream_msg_b != '0) begin
                            state  <= CALC;
                            cnt    <= '0;
                            quot_r <= in_a;
                            div_r  <= in_b;
                            rem_r  <= '0;
`ifdef DIVIDER_SIGNED_EN
                            neg_q  <= in_neg_q;
                            neg_r  <= in_neg_r;
`endif
                        end else begin
                            state  <= DONE;
                            quot_r <= '1;
                            rem_r  <= istream_msg_a;
                            div_r  <= istream_msg_b;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= DONE;
                        quot_r <= fin_quot;
                        rem_r  <= fin_rem;
                    end else begin
                        quot_r <= step_quot;
                        rem_r  <= step_rem;
                    end
                end
                DONE: begin
                    if (ostream_rdy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign istream_rdy      = (state == IDLE);
    assign ostream_val      = (state == DONE);
    assign ostream_msg_quot = quot_r;
    assign ostream_msg_rem  = rem_r;

endmodule

// File: tb/tb_divider_iterative_32b.sv
// Scoreboard bench for divider_iterative_32b: expected results queued at accept, compared at response.
module tb_divider_iterative_32b;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_val = 1'b0;
    logic         in_rdy;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         sg_i = 1'b0;
    logic         out_val;
    logic         out_rdy = 1'b0;
    logic [W-1:0] quot;
    logic [W-1:0] rem;

    int total = 0;
    int bad   = 0;
    logic [63:0] scb[$];
    logic [63:0] mon_exp;

    always #5 clk = ~clk;

    divider_iterative_32b #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .istream_val      (in_val),
        .istream_rdy      (in_rdy),
        .istream_msg_a    (a_i),
        .istream_msg_b    (b_i),
`ifdef DIVIDER_SIGNED_EN
        .istream_signed   (sg_i),
`endif
        .ostream_val      (out_val),
        .ostream_rdy      (out_rdy),
        .ostream_msg_quot (quot),
        .ostream_msg_rem  (rem)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sd;
        if (b == '0) return {{W{1'b1}}, a};
        if (sg) begin
            sa = a;
            sd = b;
            if (sa == {1'b1, {(W-1){1'b0}}} && sd == -1) return {a, {W{1'b0}}};
            return {W'(sa / sd), W'(sa % sd)};
        end
        return {a / b, a % b};
    endfunction

    // Response monitor: a response is consumed when val & rdy are both high at the edge.
    always @(negedge clk) begin
        if (!rst && out_val && out_rdy) begin
            if (scb.size() == 0) begin
                check("resp_expected", 64'(scb.size()), 64'd1);
            end else begin
                mon_exp = scb.pop_front();
                check("quot", 64'(quot), 64'(mon_exp[63:32]));
                check("rem", 64'(rem), 64'(mon_exp[31:0]));
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input bit want);
        int n;
        @(posedge clk); #1;
        a_i = a;
        b_i = b;
        in_val = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n >= 300), 64'd0);
        if (want) scb.push_back({eq, er});
        @(posedge clk); #1;
        in_val = 1'b0;
        a_i = ~a;
        b_i = ~b;
        if (want) begin
            n = 1;
            @(negedge clk);
            while (!out_val && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("latency", 64'(n), (b == '0) ? 64'd1 : 64'(W + 1));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (scb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(n >= 500), 64'd0);
    endtask

    initial begin
        logic [63:0] e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int vcount;

        // Asynchronous reset between edges, no clock edge yet
        #1 rst = 1'b1;
        #1;
        check("rst_in_rdy", 64'(in_rdy), 64'd1);
        check("rst_out_val", 64'(out_val), 64'd0);
        check("rst_quot", 64'(quot), 64'd0);
        check("rst_rem", 64'(rem), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        out_rdy = 1'b1;
        send(32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
        drain();
        send(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
        drain();
        send(32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b1);
        drain();
        send(32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
        drain();

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            e = model(ra, rb, sg_i);
            send(ra, rb, e[63:32], e[31:0], 1'b1);
            drain();
        end

        // Backpressure with a second request held during CALC and DONE
        out_rdy = 1'b0;
        @(posedge clk); #1;
        a_i = 32'd1000;
        b_i = 32'd33;
        in_val = 1'b1;
        @(negedge clk);
        check("bp_idle_rdy", 64'(in_rdy), 64'd1);
        scb.push_back({32'd30, 32'd10});
        @(posedge clk); #1;
        a_i = 32'd77;
        b_i = 32'd5;
        scb.push_back({32'd15, 32'd2});
        for (int i = 1; i <= 43; i++) begin
            @(negedge clk);
            check("busy_in_rdy", 64'(in_rdy), 64'd0);
            if (i >= 33) begin
                check("bp_val", 64'(out_val), 64'd1);
                check("bp_quot", 64'(quot), 64'd30);
                check("bp_rem", 64'(rem), 64'd10);
            end
        end
        @(posedge clk); #1;
        out_rdy = 1'b1;
        @(negedge clk);
        check("no_accept_on_consume", 64'(in_rdy), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_consume", 64'(in_rdy), 64'd1);
        @(posedge clk); #1;
        in_val = 1'b0;
        drain();

        // Abort mid-calculation
        send(32'd50000, 32'd3, 32'd0, 32'd0, 1'b0);
        repeat (16) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_in_rdy", 64'(in_rdy), 64'd1);
        check("abort_out_val", 64'(out_val), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_val) vcount++;
        end
        check("abort_no_resp", 64'(vcount), 64'd0);
        send(32'd9, 32'd3, 32'd3, 32'd0, 1'b1);
        drain();

`ifdef DIVIDER_SIGNED_EN
        sg_i = 1'b1;
        send(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
        drain();
        send(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1);
        drain();
        send(32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        drain();
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            e = model(ra, rb, sg_i);
            send(ra, rb, e[63:32], e[31:0], 1'b1);
            drain();
        end
        sg_i = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
